// File: rtl/swap_arbiter.sv
// swap_arbiter: two-requester round-robin front end with optional bit reversal into one registered output slot.
// Define SWAP_ARB_BYTE_MODE_EN to add the swapMode port, which selects byte reversal for swapped beats.
module swap_arbiter #(
    parameter int WIDTH = 48,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             req0Valid,
    input  logic [WIDTH-1:0] req0Data,
    input  logic             req0Swap,
    output logic             req0Ready,
    input  logic             req1Valid,
    input  logic [WIDTH-1:0] req1Data,
    input  logic             req1Swap,
    output logic             req1Ready,
    output logic             outValid,
    output logic [WIDTH-1:0] outData,
    output logic             outSrc,
    input  logic             outReady,
`ifdef SWAP_ARB_BYTE_MODE_EN
    input  logic             swapMode,
`endif
    output logic [CNT_W-1:0] beatCount
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;
    logic [0:0]       state;
    logic             lastGrant, grant, anyValid, drain, free, accept, selSwap;
    logic [WIDTH-1:0] selData, bitRev, xform;
    assign outValid  = state == FULL;
    assign drain     = outValid & outReady;
    assign free      = (state == EMPTY) | drain;
    assign anyValid  = req0Valid | req1Valid;
    // Contention alternates; a lone requester always wins.
    assign grant     = (req0Valid & req1Valid) ? ~lastGrant : req1Valid;
    assign accept    = free & anyValid;
    assign req0Ready = accept & ~grant;
    assign req1Ready = accept & grant;
    assign selData   = grant ? req1Data : req0Data;
    assign selSwap   = grant ? req1Swap : req0Swap;
    always_comb begin
        for (int i = 0; i < WIDTH; i++) bitRev[i] = selData[WIDTH-1-i];
    end
`ifdef SWAP_ARB_BYTE_MODE_EN
    logic [WIDTH-1:0] byteRev;
    always_comb begin
        for (int k = 0; k < WIDTH / 8; k++) byteRev[8*k +: 8] = selData[WIDTH-8-8*k +: 8];
    end
    assign xform = !selSwap ? selData : swapMode ? byteRev : bitRev;
`else
    assign xform = selSwap ? bitRev : selData;
`endif
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= EMPTY;
            outData   <= '0;
            outSrc    <= 1'b0;
            lastGrant <= 1'b1;
            beatCount <= '0;
        end else begin
            if (drain) beatCount <= beatCount + CNT_W'(1);
            if (accept) begin
                state     <= FULL;
                outData   <= xform;
                outSrc    <= grant;
                lastGrant <= grant;
            end else if (drain) begin
                state <= EMPTY;
            end
        end
    end
endmodule
